apb_reg_slave: RTL and testbench
================================

# apb_reg_slave

APB4 completer that terminates the master-side APB port of the passthrough DUT and implements a bank of 32-bit control/status registers. It responds to setup/access transactions with optional wait states, byte-strobed writes and `PSLVERR` signalling. It is the slave end of the DUT's pass-through path, and it gives the environment a real, stateful target to drive and check against.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..256.
- `BASE_ADDR`, 32'h4000_0000: byte address of register 0; aligned to `4*NUM_REGS`.
- `WAIT_CYCLES`, 2: wait states inserted per access, 0..15. Used only when the wait feature is compiled in.
- `ID_VALUE`, 32'hA5B0_0001: read-only contents of register 0.

Ports:
- `pclk` in 1: clock, rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `s_psel` in 1: select.
- `s_penable` in 1: access phase.
- `s_pwrite` in 1: 1 = write.
- `s_paddr` in 32: byte address.
- `s_pwdata` in 32: write data.
- `s_pstrb` in 4: write byte strobes.
- `s_pprot` in 3: protection; accepted, not checked.
- `s_pready` out 1: transfer complete.
- `s_pslverr` out 1: error response, valid only while `s_pready`=1.
- `s_prdata` out 32: read data, valid only while `s_pready`=1.
- `wr_evt` out 1: one-cycle pulse, asserted the cycle after a committed write.
- `wr_idx` out `$clog2(NUM_REGS)`: index of the last committed write; holds its value between writes.

## Operation
- FSM states are IDLE and ACCESS.
  - IDLE→ACCESS on `s_psel & ~s_penable`. At that edge, capture addr/write/wdata/strb and load `wcnt`=`WAIT_CYCLES`.
  - ACCESS→IDLE on `s_psel & s_penable & s_pready`. This is the completion edge.
  - ACCESS→IDLE on `~s_psel` (abort). An abort performs no write and produces no `wr_evt`.
- `s_penable`=1 while in IDLE without a prior setup cycle is ignored.
- In ACCESS, `wcnt` decrements by 1 per cycle while nonzero.
- `s_pready` = (state==ACCESS) & (`wcnt`==0). It is derived only from registered state.
- Decode uses the captured address. Register index = (addr−`BASE_ADDR`)>>2.
- An error is flagged when any of these holds:
  - addr < `BASE_ADDR`;
  - addr ≥ `BASE_ADDR`+4*`NUM_REGS`;
  - addr[1:0] ≠ 0;
  - write to index 0.
- `s_pslverr` = error & `s_pready`. An erroring write modifies nothing and raises no `wr_evt`. An erroring read returns 0.
- Write commit at the completion edge: byte k of reg[idx] takes wdata byte k when strb[k]=1.
  - `s_pstrb`=0 commits nothing, gives no error, and still pulses `wr_evt`.
- Read: `s_prdata` = reg[idx] while `s_pready`=1 and no error; otherwise 0. `s_pstrb` is ignored on reads.
- A write completing at edge E is visible to a read whose setup phase starts at E or later.

## Timing
- Reset values:
  - state IDLE, `wcnt` 0;
  - `s_pready` 0, `s_pslverr` 0, `s_prdata` 0;
  - `wr_evt` 0, `wr_idx` 0;
  - reg[0] = `ID_VALUE`, all other registers 0.
- Reset asserted mid-transfer aborts the transfer immediately (asynchronously), with no partial write.
- Setup at cycle T0, ACCESS begins at T1, and `s_pready` rises at T1+`WAIT_CYCLES`. The transfer therefore takes 2+`WAIT_CYCLES` cycles total.
- Back-to-back transfers: a setup cycle following completion is accepted on the next edge. There are no idle cycles inside the block.
- `wr_evt` is high for exactly the one cycle following the completion edge.

## Configuration
- `APB_REG_SLAVE_WAIT_EN` defined: the `wcnt` counter exists and `WAIT_CYCLES` wait states are inserted per access.
- Undefined: no counter is synthesised, `WAIT_CYCLES` is ignored, and `s_pready`=1 in the first ACCESS cycle (zero-wait, 2-cycle transfer).

## Test plan
- Reset, then read 0x4000_0000 → `s_prdata`=0xA5B0_0001, `s_pslverr`=0. With the macro defined, `s_pready` rises in the 3rd ACCESS cycle.
- Write 0x4000_0008 with data 0xDEAD_BEEF, strb 4'b1111; then write the same address with 0x1122_3344, strb 4'b0101; then read it.
  - Expected read data: 0xDE22_BE44.
  - `wr_evt` pulses twice, each time with `wr_idx`=2.
- Accesses that must error:
  - write to 0x4000_0000: reg0 unchanged;
  - read 0x4000_0040: data 0;
  - read 0x4000_0006: misaligned.
  - Each gives `s_pslverr`=1 coincident with `s_pready`, and no `wr_evt`.
- Drop `s_psel` during the wait states of a write to 0x4000_0004 with 0x0000_00FF → FSM returns to IDLE, no `wr_evt`, and a subsequent read returns 0.
- Assert `presetn` low mid-ACCESS of a write to 0x4000_000C → all outputs return to 0. After release, reg3 reads 0 and reg0 reads `ID_VALUE`.
- Back-to-back: write 0x4000_0010 then immediately read it → read returns the written value; total 2*(2+`WAIT_CYCLES`) cycles.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB4 completer with a bank of 32-bit control/status registers.
// Register 0 is a read-only ID word; writes to it error out.
// Optional wait states: define APB_REG_SLAVE_WAIT_EN to insert WAIT_CYCLES
// wait states per access. Left undefined, every transfer is zero-wait.
module apb_reg_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             s_psel,
  input  logic             s_penable,
  input  logic             s_pwrite,
  input  logic [31:0]      s_paddr,
  input  logic [31:0]      s_pwdata,
  input  logic [3:0]       s_pstrb,
  input  logic [2:0]       s_pprot,
  output logic             s_pready,
  output logic             s_pslverr,
  output logic [31:0]      s_prdata,
  output logic             wr_evt,
  output logic [IDX_W-1:0] wr_idx
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e           r_state;
  logic [31:0]      r_addr;
  logic             r_write;
  logic [31:0]      r_wdata;
  logic [3:0]       r_strb;
  logic             r_wr_evt;
  logic [IDX_W-1:0] r_wr_idx;
  logic [31:0]      r_regs [NUM_REGS];

  logic             w_wait_done;
  logic             w_pready;
  logic             w_in_range;
  logic             w_misalign;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_complete;
  logic             w_commit;
  logic             w_unused;

`ifdef APB_REG_SLAVE_WAIT_EN
  logic [3:0] r_wcnt;

  // Wait-state counter: loaded at setup, counts down to zero in ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wcnt <= 4'd0;
    end else if (r_state == StIdle) begin
      if (s_psel && !s_penable) r_wcnt <= 4'(WAIT_CYCLES);
    end else if (r_wcnt != 4'd0) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  assign w_wait_done = (r_wcnt == 4'd0);
  assign w_unused    = ^s_pprot;
`else
  assign w_wait_done = 1'b1;
  assign w_unused    = ^{s_pprot, 4'(WAIT_CYCLES)};
`endif

  // BASE_ADDR is aligned to the bank size, so range check is an upper-bit match.
  assign w_in_range = (r_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
  assign w_misalign = (r_addr[1:0] != 2'b00);
  assign w_idx      = r_addr[IDX_W+1:2];
  assign w_err      = !w_in_range || w_misalign || (r_write && (w_idx == '0));

  assign w_pready   = (r_state == StAccess) && w_wait_done;
  assign w_complete = (r_state == StAccess) && s_psel && s_penable && w_pready;
  assign w_commit   = w_complete && r_write && !w_err;

  // Response outputs, all gated by pready so they read 0 outside completion.
  always_comb begin
    s_pready  = w_pready;
    s_pslverr = w_pready && w_err;
    s_prdata  = '0;
    if (w_pready && !w_err && !r_write) s_prdata = r_regs[w_idx];
  end

  assign wr_evt = r_wr_evt;
  assign wr_idx = r_wr_idx;

  // Transfer FSM: captures the request at setup and retires it at completion or abort.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_wr_evt <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_wr_evt <= 1'b0;
      case (r_state)
        StIdle: begin
          // A bare penable without setup is ignored.
          if (s_psel && !s_penable) begin
            r_state <= StAccess;
            r_addr  <= s_paddr;
            r_write <= s_pwrite;
            r_wdata <= s_pwdata;
            r_strb  <= s_pstrb;
          end
        end
        StAccess: begin
          if (!s_psel) begin
            r_state <= StIdle;
          end else if (w_complete) begin
            r_state <= StIdle;
            if (w_commit) begin
              r_wr_evt <= 1'b1;
              r_wr_idx <= w_idx;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Register bank: byte-strobed commit; register 0 is never written.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_regs[0] <= ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          for (int k = 0; k < 4; k++) begin
            if (r_strb[k]) r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares on each completion and wr_evt pulse.
module tb_apb_reg_slave;

`ifdef APB_REG_SLAVE_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        s_psel = 1'b0;
  logic        s_penable = 1'b0;
  logic        s_pwrite = 1'b0;
  logic [31:0] s_paddr = '0;
  logic [31:0] s_pwdata = '0;
  logic [3:0]  s_pstrb = '0;
  logic [2:0]  s_pprot = '0;
  logic        s_pready;
  logic        s_pslverr;
  logic [31:0] s_prdata;
  logic        wr_evt;
  logic [3:0]  wr_idx;

  apb_reg_slave #(
    .NUM_REGS   (16),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(2),
    .ID_VALUE   (ID)
  ) u_dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .s_psel   (s_psel),
    .s_penable(s_penable),
    .s_pwrite (s_pwrite),
    .s_paddr  (s_paddr),
    .s_pwdata (s_pwdata),
    .s_pstrb  (s_pstrb),
    .s_pprot  (s_pprot),
    .s_pready (s_pready),
    .s_pslverr(s_pslverr),
    .s_prdata (s_prdata),
    .wr_evt   (wr_evt),
    .wr_idx   (wr_idx)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] evt_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         acc_cnt = 0;
  exp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares each completed transfer and each wr_evt pulse.
  always @(negedge pclk) begin
    if (presetn && s_psel && s_penable) begin
      acc_cnt++;
      if (s_pready) begin
        check("access_cycles", 32'(acc_cnt), 32'(1 + WAITS));
        acc_cnt = 0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL completion: unexpected transfer at addr %h", s_paddr);
        end else begin
          mon_e = exp_q.pop_front();
          check("pslverr", {31'd0, s_pslverr}, {31'd0, mon_e.err});
          if (mon_e.chk_data) check("prdata", s_prdata, mon_e.data);
        end
      end
    end else begin
      acc_cnt = 0;
    end
    if (presetn && wr_evt) begin
      if (evt_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_evt: unexpected pulse with wr_idx %0d, expected none", wr_idx);
      end else begin
        check("wr_idx", {28'd0, wr_idx}, {28'd0, evt_q.pop_front()});
      end
    end
  end

  // Full APB transfer; called and returns 1 ns after a rising edge.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    int   budget;
    e.chk_data = !wr;
    e.data     = exp_data;
    e.err      = exp_err;
    exp_q.push_back(e);
    if (wr && !exp_err) evt_q.push_back(4'((addr - BASE) >> 2));
    s_psel    = 1'b1;
    s_penable = 1'b0;
    s_pwrite  = wr;
    s_paddr   = addr;
    s_pwdata  = wdata;
    s_pstrb   = strb;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    budget = 0;
    while (!s_pready && budget < 40) begin
      @(posedge pclk); #1;
      budget++;
    end
    if (!s_pready) begin
      n_vec++;
      n_err++;
      $display("FAIL pready_timeout: got no pready in %0d cycles, expected %0d", budget, WAITS);
    end
    @(posedge pclk); #1;
    s_psel    = 1'b0;
    s_penable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    apb(1'b0, addr, 32'h0, 4'h0, exp_data, exp_err);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic exp_err);
    apb(1'b1, addr, data, strb, 32'h0, exp_err);
  endtask

  time t0;

  initial begin
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    check("rst_pready", {31'd0, s_pready}, 32'd0);
    check("rst_pslverr", {31'd0, s_pslverr}, 32'd0);
    check("rst_prdata", s_prdata, 32'd0);
    check("rst_wr_evt", {31'd0, wr_evt}, 32'd0);
    check("rst_wr_idx", {28'd0, wr_idx}, 32'd0);

    // ID register and byte-strobed writes.
    rd(BASE, ID, 1'b0);
    wr(BASE + 32'h08, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    wr(BASE + 32'h08, 32'h1122_3344, 4'b0101, 1'b0);
    rd(BASE + 32'h08, 32'hDE22_BE44, 1'b0);
    wr(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd(BASE + 32'h08, 32'hDE22_BE44, 1'b0);
    wr(BASE + 32'h3C, 32'h0BAD_F00D, 4'b1111, 1'b0);
    rd(BASE + 32'h3C, 32'h0BAD_F00D, 1'b0);

    // Error cases.
    wr(BASE, 32'h1234_5678, 4'b1111, 1'b1);
    rd(BASE, ID, 1'b0);
    rd(BASE + 32'h40, 32'h0, 1'b1);
    rd(BASE + 32'h06, 32'h0, 1'b1);
    rd(BASE - 32'h4, 32'h0, 1'b1);
    wr(BASE + 32'h40, 32'h1234_5678, 4'b1111, 1'b1);

    // Abort a write by dropping psel before completion.
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1;
    s_paddr = BASE + 32'h04; s_pwdata = 32'h0000_00FF; s_pstrb = 4'b1111;
    @(posedge pclk); #1;
    if (WAITS > 0) begin
      s_penable = 1'b1;
      @(posedge pclk); #1;
    end
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge pclk); #1;
    check("abort_pready", {31'd0, s_pready}, 32'd0);
    rd(BASE + 32'h04, 32'h0, 1'b0);

    // Back-to-back write then read.
    t0 = $time;
    wr(BASE + 32'h10, 32'hCAFE_F00D, 4'b1111, 1'b0);
    rd(BASE + 32'h10, 32'hCAFE_F00D, 1'b0);
    check("b2b_cycles", 32'(($time - t0) / 10), 32'(2 * (2 + WAITS)));

    // Reset in the middle of an ACCESS phase.
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1;
    s_paddr = BASE + 32'h0C; s_pwdata = 32'h1234_5678; s_pstrb = 4'b1111;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    #3 presetn = 1'b0;
    #1;
    check("mid_rst_pready", {31'd0, s_pready}, 32'd0);
    check("mid_rst_pslverr", {31'd0, s_pslverr}, 32'd0);
    check("mid_rst_prdata", s_prdata, 32'd0);
    check("mid_rst_wr_evt", {31'd0, wr_evt}, 32'd0);
    check("mid_rst_wr_idx", {28'd0, wr_idx}, 32'd0);
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    rd(BASE + 32'h0C, 32'h0, 1'b0);
    rd(BASE, ID, 1'b0);
    rd(BASE + 32'h08, 32'h0, 1'b0);

    repeat (3) @(posedge pclk);
    #1;
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("evt_q_left", 32'(evt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
